// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative multiply/divide unit.
//   op_e    - operation codes presented on muldiv_unit.op
//   state_e - controller states (IDLE -> RUN -> FIX -> IDLE)
//   OP_W    - width of the op field
package muldiv_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one iteration of the unsigned magnitude datapath.
// Build option: MULDIV_DIV_EN adds the restoring-divide path and the is_div port.
// Ports:
//   is_div   - (MULDIV_DIV_EN only) select divide step instead of multiply step
//   acc_hi   - multiply: partial product high half / divide: partial remainder
//   acc_lo   - multiply: remaining multiplier bits  / divide: dividend shifting into quotient
//   opnd     - multiplicand magnitude or divisor magnitude
//   hi_next, lo_next - accumulator after this iteration
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
`ifdef MULDIV_DIV_EN
    input  logic             is_div,
`endif
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next
);

    // Shift-add: add the multiplicand when the multiplier LSB is set, then
    // shift the {carry, hi, lo} triple right one place.
    logic [WIDTH:0] mul_sum;
    assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});

`ifdef MULDIV_DIV_EN
    // Restoring divide: shift the next dividend bit into the remainder and keep
    // the trial difference only when it does not go negative.
    logic [WIDTH:0] div_shift;
    logic [WIDTH:0] div_trial;
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, opnd};

    always_comb begin
        hi_next = mul_sum[WIDTH:1];
        lo_next = {mul_sum[0], acc_lo[WIDTH-1:1]};
        if (is_div) begin
            if (!div_trial[WIDTH]) begin
                hi_next = div_trial[WIDTH-1:0];
                lo_next = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_next = div_shift[WIDTH-1:0];
                lo_next = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end
    end
`else
    assign hi_next = mul_sum[WIDTH:1];
    assign lo_next = {mul_sum[0], acc_lo[WIDTH-1:1]};
`endif

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU with HI/LO registers and MTHI/MTLO.
// Build option: define MULDIV_DIV_EN to build the divider; without it DIV/DIVU
// starts are rejected with a one-cycle err pulse.
// Ports:
//   clk, reset      - clock, asynchronous active-high reset
//   start, op, a, b - operation request (sampled in IDLE only)
//   cancel          - abort an operation in RUN or FIX
//   busy            - operation in RUN or FIX
//   done            - one-cycle pulse when new hi/lo are visible
//   err             - one-cycle pulse for a rejected start
//   hi, lo          - architectural HI/LO registers
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_e             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic [WIDTH-1:0]   acc_hi_reg, acc_lo_reg, opnd_reg;
    logic               neg_q_reg;
    logic [WIDTH-1:0]   hi_reg, lo_reg;
    logic               done_reg, err_reg;
    logic               run_step, fix_commit;
    logic [WIDTH-1:0]   step_hi, step_lo;

    // Request decode
    op_e              op_in;
    logic             op_mul, op_divide, op_signed;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             launch, reject;

    assign op_in     = op_e'(op);
    assign op_mul    = (op_in == OP_MULT) || (op_in == OP_MULTU);
    assign op_divide = (op_in == OP_DIV)  || (op_in == OP_DIVU);
    assign op_signed = (op_in == OP_MULT) || (op_in == OP_DIV);
    assign a_neg     = op_signed && a[WIDTH-1];
    assign b_neg     = op_signed && b[WIDTH-1];
    // The most negative value maps to itself, which is its correct unsigned magnitude.
    assign a_mag     = a_neg ? -a : a;
    assign b_mag     = b_neg ? -b : b;

`ifdef MULDIV_DIV_EN
    logic is_div_reg, neg_r_reg, div_zero_reg;
    assign launch = start && (op_mul || op_divide);
    assign reject = 1'b0;
`else
    assign launch = start && op_mul;
    assign reject = start && op_divide;
`endif

    // Sign correction applied in FIX
    logic [2*WIDTH-1:0] prod_raw, prod_fix;
    logic [WIDTH-1:0]   res_hi, res_lo;
    assign prod_raw = {acc_hi_reg, acc_lo_reg};
    assign prod_fix = neg_q_reg ? -prod_raw : prod_raw;

`ifdef MULDIV_DIV_EN
    logic [WIDTH-1:0] quo_fix, rem_fix;
    // Divide by zero: the restoring loop leaves |a| in the remainder, so the
    // dividend-sign correction restores a exactly; only the quotient is forced.
    assign quo_fix = div_zero_reg ? {WIDTH{1'b1}} : (neg_q_reg ? -acc_lo_reg : acc_lo_reg);
    assign rem_fix = neg_r_reg ? -acc_hi_reg : acc_hi_reg;
    assign res_hi  = is_div_reg ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
    assign res_lo  = is_div_reg ? quo_fix : prod_fix[WIDTH-1:0];
`else
    assign res_hi  = prod_fix[2*WIDTH-1:WIDTH];
    assign res_lo  = prod_fix[WIDTH-1:0];
`endif

    muldiv_step #(.WIDTH(WIDTH)) u_step (
`ifdef MULDIV_DIV_EN
        .is_div  (is_div_reg),
`endif
        .acc_hi  (acc_hi_reg),
        .acc_lo  (acc_lo_reg),
        .opnd    (opnd_reg),
        .hi_next (step_hi),
        .lo_next (step_lo)
    );

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    // FSM: next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (launch) state_next = ST_RUN;
            ST_RUN: begin
                if (cancel)                             state_next = ST_IDLE;
                else if (cnt_reg == CNT_W'(WIDTH - 1))  state_next = ST_FIX;
            end
            ST_FIX:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy       = (state_reg == ST_RUN) || (state_reg == ST_FIX);
        run_step   = (state_reg == ST_RUN) && !cancel;
        fix_commit = (state_reg == ST_FIX) && !cancel;
    end

    // Datapath and architectural registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg      <= '0;
            acc_hi_reg   <= '0;
            acc_lo_reg   <= '0;
            opnd_reg     <= '0;
            neg_q_reg    <= 1'b0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
`ifdef MULDIV_DIV_EN
            is_div_reg   <= 1'b0;
            neg_r_reg    <= 1'b0;
            div_zero_reg <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            if (state_reg == ST_IDLE) begin
                if (launch) begin
                    cnt_reg    <= '0;
                    acc_hi_reg <= '0;
                    neg_q_reg  <= a_neg ^ b_neg;
`ifdef MULDIV_DIV_EN
                    is_div_reg   <= op_divide;
                    neg_r_reg    <= a_neg;
                    div_zero_reg <= (b == '0);
                    opnd_reg     <= op_divide ? b_mag : a_mag;
                    acc_lo_reg   <= op_divide ? a_mag : b_mag;
`else
                    opnd_reg     <= a_mag;
                    acc_lo_reg   <= b_mag;
`endif
                end else if (start && op_in == OP_MTHI) begin
                    hi_reg <= a;
                end else if (start && op_in == OP_MTLO) begin
                    lo_reg <= a;
                end else if (reject) begin
                    err_reg <= 1'b1;
                end
            end
            if (run_step) begin
                acc_hi_reg <= step_hi;
                acc_lo_reg <= step_lo;
                cnt_reg    <= cnt_reg + CNT_W'(1);
            end
            if (fix_commit) begin
                hi_reg   <= res_hi;
                lo_reg   <= res_lo;
                done_reg <= 1'b1;
            end
        end
    end

    assign done = done_reg;
    assign err  = err_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed checks of muldiv_unit (WIDTH=32)
// against an arithmetic reference model. Works with or without MULDIV_DIV_EN.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start, cancel;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done, err;
    logic [W-1:0] hi, lo;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_hi, exp_lo;   // expected architectural HI/LO

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .cancel(cancel), .busy(busy), .done(done), .err(err), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Reference model: {hi, lo} from plain integer arithmetic.
    function automatic logic [2*W-1:0] ref_result(input logic [2:0] o, input logic [W-1:0] av,
                                                  input logic [W-1:0] bv);
        longint sa, sb;
        int qa, qb;
        logic [2*W-1:0] r;
        r = '0;
        case (o)
            OP_MULT: begin
                sa = longint'($signed(av));
                sb = longint'($signed(bv));
                r  = 64'(sa * sb);
            end
            OP_MULTU: r = {32'd0, av} * {32'd0, bv};
            OP_DIV: begin
                if (bv == 0) r = {av, 32'hFFFF_FFFF};
                else if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
                else begin
                    qa = $signed(av);
                    qb = $signed(bv);
                    r  = {32'(qa % qb), 32'(qa / qb)};
                end
            end
            OP_DIVU: begin
                if (bv == 0) r = {av, 32'hFFFF_FFFF};
                else         r = {av % bv, av / bv};
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    // Issue one request and follow it for up to 40 edges. Edges are numbered
    // with the start edge as edge 1. cancel_at: edge index after which cancel is
    // held for one cycle (0 = together with start, -1 = never). restart_at: edge
    // index after which a second start with other operands is attempted.
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input int cancel_at, input int restart_at,
                          output logic [W-1:0] rh, output logic [W-1:0] rl,
                          output int done_edge, output int busy_cnt, output int err_cnt,
                          output logic done_twice);
        int e;
        @(negedge clk);
        start = 1'b1; op = o; a = av; b = bv; cancel = (cancel_at == 0);
        @(negedge clk);
        e = 1; done_edge = 0; busy_cnt = 0; err_cnt = 0; done_twice = 1'b0;
        start = 1'b0; cancel = 1'b0; a = $urandom; b = $urandom;
        while (done_edge == 0 && e <= 40) begin
            if (done) done_edge = e;
            else begin
                if (busy) busy_cnt++;
                if (err)  err_cnt++;
                cancel = (e == cancel_at);
                start  = (e == restart_at);
                @(negedge clk);
                e++;
            end
        end
        rh = hi; rl = lo;
        start = 1'b0; cancel = 1'b0;
        if (done_edge != 0) begin
            @(negedge clk);
            done_twice = done;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; cancel = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (err  !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
        n_checks++; if (hi !== 32'd0)  begin n_fail++; $display("FAIL reset_hi: got %h want 0", hi); end
        n_checks++; if (lo !== 32'd0)  begin n_fail++; $display("FAIL reset_lo: got %h want 0", lo); end
        reset = 1'b0;
        exp_hi = '0; exp_lo = '0;
        $display("reset: hi=%h lo=%h busy=%b", hi, lo, busy);
    endtask

    task automatic test_mult_directed;
        logic [W-1:0] rh, rl; int de, bc, ec; logic dt;
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, rh, rl, de, bc, ec, dt);
        $display("MULTU ffffffff*ffffffff -> hi=%h lo=%h done_edge=%0d busy=%0d", rh, rl, de, bc);
        n_checks++; if (rh !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_max_hi: got %h want fffffffe", rh); end
        n_checks++; if (rl !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_max_lo: got %h want 00000001", rl); end
        n_checks++; if (de != 34) begin n_fail++; $display("FAIL multu_latency: got edge %0d want 34", de); end
        n_checks++; if (bc != 33) begin n_fail++; $display("FAIL multu_busy_cycles: got %0d want 33", bc); end
        n_checks++; if (dt !== 1'b0) begin n_fail++; $display("FAIL multu_done_single: done still high"); end
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, -1, -1, rh, rl, de, bc, ec, dt);
        $display("MULT -3*5 -> hi=%h lo=%h", rh, rl);
        n_checks++; if (rh !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_neg_hi: got %h want ffffffff", rh); end
        n_checks++; if (rl !== 32'hFFFF_FFF1) begin n_fail++; $display("FAIL mult_neg_lo: got %h want fffffff1", rl); end
        exp_hi = rh; exp_lo = rl;
    endtask

    task automatic test_mult_random;
        logic [W-1:0] rh, rl, av, bv; int de, bc, ec; logic dt; logic [2:0] o; logic [2*W-1:0] ex;
        for (int i = 0; i < 12; i++) begin
            o  = ($urandom_range(0, 1) == 0) ? OP_MULT : OP_MULTU;
            av = $urandom; bv = $urandom;
            if (i == 3) av = 32'h8000_0000;
            if (i == 4) bv = 32'h0;
            ex = ref_result(o, av, bv);
            run_op(o, av, bv, -1, -1, rh, rl, de, bc, ec, dt);
            $display("op=%0d a=%h b=%h -> hi=%h lo=%h", o, av, bv, rh, rl);
            n_checks++; if (rh !== ex[63:32]) begin n_fail++; $display("FAIL mul_rand_hi: got %h want %h", rh, ex[63:32]); end
            n_checks++; if (rl !== ex[31:0])  begin n_fail++; $display("FAIL mul_rand_lo: got %h want %h", rl, ex[31:0]); end
            n_checks++; if (de != 34) begin n_fail++; $display("FAIL mul_rand_latency: got %0d want 34", de); end
            exp_hi = ex[63:32]; exp_lo = ex[31:0];
        end
    endtask

`ifdef MULDIV_DIV_EN
    task automatic test_div;
        logic [W-1:0] rh, rl, av, bv; int de, bc, ec; logic dt; logic [2:0] o; logic [2*W-1:0] ex;
        logic [2:0]   d_op [4] = '{OP_DIV, OP_DIV, OP_DIVU, OP_DIV};
        logic [W-1:0] d_a  [4] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'd5, 32'hFFFF_FFF7};
        logic [W-1:0] d_b  [4] = '{32'd2, 32'hFFFF_FFFF, 32'd0, 32'd0};
        logic [W-1:0] d_hi [4] = '{32'hFFFF_FFFF, 32'd0, 32'd5, 32'hFFFF_FFF7};
        logic [W-1:0] d_lo [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        for (int i = 0; i < 4; i++) begin
            run_op(d_op[i], d_a[i], d_b[i], -1, -1, rh, rl, de, bc, ec, dt);
            $display("div op=%0d a=%h b=%h -> hi=%h lo=%h err=%0d", d_op[i], d_a[i], d_b[i], rh, rl, ec);
            n_checks++; if (rh !== d_hi[i]) begin n_fail++; $display("FAIL div_dir_hi[%0d]: got %h want %h", i, rh, d_hi[i]); end
            n_checks++; if (rl !== d_lo[i]) begin n_fail++; $display("FAIL div_dir_lo[%0d]: got %h want %h", i, rl, d_lo[i]); end
            n_checks++; if (de != 34 || ec != 0) begin n_fail++; $display("FAIL div_dir_timing[%0d]: edge %0d err %0d want 34/0", i, de, ec); end
        end
        for (int i = 0; i < 12; i++) begin
            o  = ($urandom_range(0, 1) == 0) ? OP_DIV : OP_DIVU;
            av = $urandom;
            case ($urandom_range(0, 2))
                0:       bv = $urandom;
                1:       bv = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 20)) : -32'($urandom_range(1, 20));
                default: bv = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 1000));
            endcase
            ex = ref_result(o, av, bv);
            run_op(o, av, bv, -1, -1, rh, rl, de, bc, ec, dt);
            $display("div op=%0d a=%h b=%h -> hi=%h lo=%h", o, av, bv, rh, rl);
            n_checks++; if (rh !== ex[63:32]) begin n_fail++; $display("FAIL div_rand_hi: got %h want %h", rh, ex[63:32]); end
            n_checks++; if (rl !== ex[31:0])  begin n_fail++; $display("FAIL div_rand_lo: got %h want %h", rl, ex[31:0]); end
            exp_hi = ex[63:32]; exp_lo = ex[31:0];
        end
    endtask
`else
    task automatic test_div_reject;
        logic [W-1:0] rh, rl; int de, bc, ec; logic dt;
        @(negedge clk); start = 1'b1; op = OP_MTHI; a = 32'hCAFE;
        @(negedge clk); op = OP_MTLO; a = 32'hBEEF;
        @(negedge clk); start = 1'b0;
        exp_hi = 32'hCAFE; exp_lo = 32'hBEEF;
        run_op(OP_DIVU, 32'd5, 32'd0, -1, -1, rh, rl, de, bc, ec, dt);
        $display("DIVU (no divider) -> err_cycles=%0d busy=%0d hi=%h lo=%h", ec, bc, rh, rl);
        n_checks++; if (ec != 1)  begin n_fail++; $display("FAIL reject_err_pulse: got %0d cycles want 1", ec); end
        n_checks++; if (bc != 0)  begin n_fail++; $display("FAIL reject_busy: got %0d cycles want 0", bc); end
        n_checks++; if (de != 0)  begin n_fail++; $display("FAIL reject_done: done at edge %0d want none", de); end
        n_checks++; if (rh !== exp_hi) begin n_fail++; $display("FAIL reject_hi: got %h want %h", rh, exp_hi); end
        n_checks++; if (rl !== exp_lo) begin n_fail++; $display("FAIL reject_lo: got %h want %h", rl, exp_lo); end
    endtask
`endif

    task automatic test_mthi_cancel;
        logic [W-1:0] rh, rl, av, bv; int de, bc, ec; logic dt; logic [2*W-1:0] ex;
        @(negedge clk); cancel = 1'b1;
        @(negedge clk); cancel = 1'b0;
        n_checks++; if (busy !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
            n_fail++; $display("FAIL idle_cancel: busy=%b hi=%h lo=%h want 0/%h/%h", busy, hi, lo, exp_hi, exp_lo); end
        start = 1'b1; op = OP_MTHI; a = 32'h1234;
        @(negedge clk); start = 1'b0;
        $display("MTHI 1234 -> hi=%h busy=%b done=%b", hi, busy, done);
        n_checks++; if (hi !== 32'h1234) begin n_fail++; $display("FAIL mthi_hi: got %h want 00001234", hi); end
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL mthi_flags: busy=%b done=%b want 0/0", busy, done); end
        n_checks++; if (lo !== exp_lo) begin n_fail++; $display("FAIL mthi_lo_kept: got %h want %h", lo, exp_lo); end
        start = 1'b1; op = OP_MTLO; a = 32'h5678;
        @(negedge clk); start = 1'b0;
        n_checks++; if (lo !== 32'h5678 || hi !== 32'h1234) begin n_fail++; $display("FAIL mtlo: hi=%h lo=%h want 00001234/00005678", hi, lo); end
        exp_hi = 32'h1234; exp_lo = 32'h5678;

        run_op(OP_MULTU, $urandom | 32'h1, $urandom | 32'h1, 10, -1, rh, rl, de, bc, ec, dt);
        $display("MULTU cancel@run10 -> hi=%h lo=%h busy_cycles=%0d done_edge=%0d", rh, rl, bc, de);
        n_checks++; if (rh !== exp_hi || rl !== exp_lo) begin n_fail++; $display("FAIL cancel_run_hilo: %h/%h want %h/%h", rh, rl, exp_hi, exp_lo); end
        n_checks++; if (bc != 10) begin n_fail++; $display("FAIL cancel_run_busy: got %0d cycles want 10", bc); end
        n_checks++; if (de != 0)  begin n_fail++; $display("FAIL cancel_run_done: done at edge %0d want none", de); end

        run_op(OP_MULT, $urandom | 32'h1, $urandom | 32'h1, 33, -1, rh, rl, de, bc, ec, dt);
        $display("MULT cancel@fix -> hi=%h lo=%h busy_cycles=%0d done_edge=%0d", rh, rl, bc, de);
        n_checks++; if (rh !== exp_hi || rl !== exp_lo) begin n_fail++; $display("FAIL cancel_fix_hilo: %h/%h want %h/%h", rh, rl, exp_hi, exp_lo); end
        n_checks++; if (de != 0 || bc != 33) begin n_fail++; $display("FAIL cancel_fix: done_edge %0d busy %0d want 0/33", de, bc); end

        av = $urandom; bv = $urandom; ex = ref_result(OP_MULTU, av, bv);
        run_op(OP_MULTU, av, bv, -1, 5, rh, rl, de, bc, ec, dt);
        $display("MULTU with start while busy -> hi=%h lo=%h err=%0d", rh, rl, ec);
        n_checks++; if (rh !== ex[63:32] || rl !== ex[31:0]) begin n_fail++; $display("FAIL busy_start_result: %h/%h want %h/%h", rh, rl, ex[63:32], ex[31:0]); end
        n_checks++; if (ec != 0 || de != 34 || dt !== 1'b0) begin n_fail++; $display("FAIL busy_start_ignored: err %0d edge %0d again %b", ec, de, dt); end
        exp_hi = ex[63:32]; exp_lo = ex[31:0];

        av = $urandom; bv = $urandom; ex = ref_result(OP_MULT, av, bv);
        run_op(OP_MULT, av, bv, 0, -1, rh, rl, de, bc, ec, dt);
        $display("MULT with cancel+start -> hi=%h lo=%h done_edge=%0d", rh, rl, de);
        n_checks++; if (de != 34 || rh !== ex[63:32] || rl !== ex[31:0]) begin
            n_fail++; $display("FAIL start_beats_cancel: edge %0d %h/%h want 34 %h/%h", de, rh, rl, ex[63:32], ex[31:0]); end
        exp_hi = ex[63:32]; exp_lo = ex[31:0];
    endtask

    task automatic test_reset_mid_run;
        logic saw_done, saw_busy;
        @(negedge clk); start = 1'b1; op = OP_MTHI; a = 32'hA5A5;
        @(negedge clk); op = OP_MTLO; a = 32'h5A5A;
        @(negedge clk); op = OP_MULTU; a = $urandom | 32'h1; b = $urandom | 32'h1;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        $display("reset mid-run -> hi=%h lo=%h busy=%b", hi, lo, busy);
        n_checks++; if (hi !== 32'd0 || lo !== 32'd0) begin n_fail++; $display("FAIL midrun_reset_hilo: %h/%h want 0/0", hi, lo); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrun_reset_busy: got %b want 0", busy); end
        @(negedge clk); reset = 1'b0;
        exp_hi = '0; exp_lo = '0;
        saw_done = 1'b0; saw_busy = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
            if (busy) saw_busy = 1'b1;
        end
        n_checks++; if (saw_done !== 1'b0 || saw_busy !== 1'b0) begin n_fail++; $display("FAIL midrun_reset_after: done=%b busy=%b want 0/0", saw_done, saw_busy); end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] av, bv; logic [2:0] o; logic [2*W-1:0] ex; int e;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
`ifdef MULDIV_DIV_EN
            o = 3'($urandom_range(0, 3));
`else
            o = 3'($urandom_range(0, 1));
`endif
            av = $urandom; bv = $urandom;
            ex = ref_result(o, av, bv);
            start = 1'b1; op = o; a = av; b = bv;
            @(negedge clk);
            start = 1'b0; e = 1;
            while (!done && e < 40) begin
                @(negedge clk);
                e++;
            end
            $display("b2b op=%0d a=%h b=%h -> hi=%h lo=%h edge=%0d", o, av, bv, hi, lo, e);
            n_checks++; if (e != 34) begin n_fail++; $display("FAIL b2b_latency[%0d]: got %0d want 34", i, e); end
            n_checks++; if (hi !== ex[63:32] || lo !== ex[31:0]) begin
                n_fail++; $display("FAIL b2b_result[%0d]: %h/%h want %h/%h", i, hi, lo, ex[63:32], ex[31:0]); end
        end
    endtask

    initial begin
        test_reset();
        test_mult_directed();
        test_mult_random();
`ifdef MULDIV_DIV_EN
        test_div();
`else
        test_div_reject();
`endif
        test_mthi_cancel();
        test_reset_mid_run();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
